// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding imem
// requests and fills the IF/ID register, honouring redirects, stalls and flushes.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_F_i,
    input  logic        stall_D_i,
    input  logic        flush_D_i,
    input  logic        pc_src_i,
    input  logic [31:0] pc_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_D_o,
    output logic [31:0] pc_D_o,
    output logic [31:0] pc_plus4_D_o,
    output logic        valid_D_o,
    output logic        fetch_busy_o
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc_f, pc_f_next;
    logic [XLEN-1:0] pc_req, pc_req_next;
    logic            kill, kill_next;
    logic [XLEN-1:0] buf_instr, buf_next;

    logic [XLEN-1:0] instr_d, instr_d_next;
    logic [XLEN-1:0] pc_d, pc_d_next;
    logic [XLEN-1:0] pc4_d, pc4_d_next;
    logic            valid_d, valid_d_next;

    logic            deliver;
    logic [XLEN-1:0] deliver_instr;
    logic [XLEN-1:0] target;

    assign target       = pc_target_i & ~XLEN'(3);
    assign imem_req_o   = (state == S_REQ) && !stall_F_i;
    assign imem_addr_o  = pc_f;
    assign fetch_busy_o = (state != S_REQ);

    assign instr_D_o    = instr_d;
    assign pc_D_o       = pc_d;
    assign pc_plus4_D_o = pc4_d;
    assign valid_D_o    = valid_d;

    // State and IF/ID register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= S_REQ;
            pc_f      <= RESET_PC;
            pc_req    <= RESET_PC;
            kill      <= 1'b0;
            buf_instr <= '0;
            instr_d   <= NOP_INSTR;
            pc_d      <= '0;
            pc4_d     <= '0;
            valid_d   <= 1'b0;
        end else begin
            state     <= state_next;
            pc_f      <= pc_f_next;
            pc_req    <= pc_req_next;
            kill      <= kill_next;
            buf_instr <= buf_next;
            instr_d   <= instr_d_next;
            pc_d      <= pc_d_next;
            pc4_d     <= pc4_d_next;
            valid_d   <= valid_d_next;
        end
    end

    // Next-state, PC update and IF/ID load selection
    always_comb begin
        state_next    = state;
        pc_f_next     = pc_f;
        pc_req_next   = pc_req;
        kill_next     = kill;
        buf_next      = buf_instr;
        deliver       = 1'b0;
        deliver_instr = buf_instr;

        unique case (state)
            S_REQ: begin
                if (imem_req_o && imem_gnt_i) begin
                    pc_req_next = pc_f;
                    pc_f_next   = pc_src_i ? target : pc_f + PC_STEP;
                    kill_next   = pc_src_i;
                    state_next  = S_WAIT;
                end else if (pc_src_i) begin
                    pc_f_next = target;
                end
            end
            S_WAIT: begin
                if (pc_src_i) begin
                    pc_f_next = target;
                    kill_next = 1'b1;
                end
                if (imem_rvalid_i) begin
                    state_next = S_REQ;
                    // A flushed IF/ID cannot take the word, so it is dropped.
                    if (kill || pc_src_i) begin
                        kill_next = 1'b0;
                    end else if (flush_D_i) begin
                        kill_next = 1'b0;
                    end else if (stall_D_i) begin
                        buf_next   = imem_rdata_i;
                        state_next = S_HOLD;
                    end else begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata_i;
                    end
                end
            end
            S_HOLD: begin
                if (pc_src_i) begin
                    pc_f_next  = target;
                    state_next = S_REQ;
                end else if (flush_D_i) begin
                    state_next = S_REQ;
                end else if (!stall_D_i) begin
                    deliver       = 1'b1;
                    deliver_instr = buf_instr;
                    state_next    = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase

        instr_d_next = instr_d;
        pc_d_next    = pc_d;
        pc4_d_next   = pc4_d;
        valid_d_next = valid_d;
        if (flush_D_i) begin
            instr_d_next = NOP_INSTR;
            pc_d_next    = '0;
            pc4_d_next   = '0;
            valid_d_next = 1'b0;
        end else if (stall_D_i) begin
            valid_d_next = valid_d;
        end else if (deliver) begin
            instr_d_next = deliver_instr;
            pc_d_next    = pc_req;
            pc4_d_next   = pc_req + PC_STEP;
            valid_d_next = 1'b1;
        end else begin
            instr_d_next = NOP_INSTR;
            valid_d_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of the
// fetch pipeline (next PC, one in-flight request, one parked word, IF/ID).
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        stall_F_i = 1'b0, stall_D_i = 1'b0, flush_D_i = 1'b0;
    logic        pc_src_i = 1'b0;
    logic [31:0] pc_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instr_D_o, pc_D_o, pc_plus4_D_o;
    logic        valid_D_o, fetch_busy_o;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .stall_F_i(stall_F_i), .stall_D_i(stall_D_i), .flush_D_i(flush_D_i),
        .pc_src_i(pc_src_i), .pc_target_i(pc_target_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_D_o(instr_D_o), .pc_D_o(pc_D_o), .pc_plus4_D_o(pc_plus4_D_o),
        .valid_D_o(valid_D_o), .fetch_busy_o(fetch_busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Model: next fetch PC, in-flight request, parked word and IF/ID contents
    logic [31:0] m_pc, m_addr, m_park, m_instr, m_pcd, m_pc4;
    logic        m_inflight, m_stale, m_parked, m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_1234;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_addr = RST_PC; m_park = '0;
        m_inflight = 1'b0; m_stale = 1'b0; m_parked = 1'b0;
        m_valid = 1'b0; m_instr = NOP; m_pcd = '0; m_pc4 = '0;
    endtask

    task automatic model_step(input logic src, input logic [31:0] tgt, input logic sf,
                              input logic sd, input logic fl, input logic g,
                              input logic rv, input logic [31:0] rd);
        logic [31:0] tg;
        logic        dv;
        logic [31:0] di;
        tg = tgt & 32'hFFFF_FFFC;
        dv = 1'b0;
        di = '0;
        if (!m_inflight && !m_parked) begin
            if (!sf && g) begin
                m_inflight = 1'b1;
                m_addr     = m_pc;
                m_stale    = src;
                m_pc       = src ? tg : m_pc + 32'd4;
            end else if (src) begin
                m_pc = tg;
            end
        end else if (m_inflight) begin
            if (src) begin
                m_pc    = tg;
                m_stale = 1'b1;
            end
            if (rv) begin
                m_inflight = 1'b0;
                if (!m_stale && !fl) begin
                    if (sd) begin
                        m_parked = 1'b1;
                        m_park   = rd;
                    end else begin
                        dv = 1'b1;
                        di = rd;
                    end
                end
                m_stale = 1'b0;
            end
        end else begin
            if (src || fl) begin
                m_parked = 1'b0;
            end else if (!sd) begin
                dv = 1'b1;
                di = m_park;
                m_parked = 1'b0;
            end
            if (src) m_pc = tg;
        end
        if (fl) begin
            m_valid = 1'b0; m_instr = NOP; m_pcd = '0; m_pc4 = '0;
        end else if (!sd) begin
            if (dv) begin
                m_valid = 1'b1; m_instr = di; m_pcd = m_addr; m_pc4 = m_addr + 32'd4;
            end else begin
                m_valid = 1'b0; m_instr = NOP;
            end
        end
    endtask

    // One clock: drive inputs at negedge, compare, advance the model
    task automatic cycle(input logic src, input logic [31:0] tgt, input logic sf,
                         input logic sd, input logic fl, input logic g,
                         input logic rv, input logic [31:0] rd);
        pc_src_i = src; pc_target_i = tgt; stall_F_i = sf; stall_D_i = sd;
        flush_D_i = fl; imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd;
        #1;
        check("req", {31'b0, imem_req_o}, {31'b0, !m_inflight && !m_parked && !sf});
        check("addr", imem_addr_o, m_pc);
        check("busy", {31'b0, fetch_busy_o}, {31'b0, m_inflight || m_parked});
        check("valid_D", {31'b0, valid_D_o}, {31'b0, m_valid});
        check("instr_D", instr_D_o, m_instr);
        check("pc_D", pc_D_o, m_pcd);
        check("pc_plus4_D", pc_plus4_D_o, m_pc4);
        model_step(src, tgt, sf, sd, fl, g, rv, rd);
        @(negedge clk_i);
    endtask

    // Asynchronous reset with a stray rvalid during and after it
    task automatic do_reset();
        reset_i = 1'b1;
        pc_src_i = 1'b0; stall_F_i = 1'b0; stall_D_i = 1'b0; flush_D_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
        #1;
        check("rst_instr", instr_D_o, NOP);
        check("rst_valid", {31'b0, valid_D_o}, 32'd0);
        check("rst_pc_D", pc_D_o, 32'd0);
        check("rst_pc4_D", pc_plus4_D_o, 32'd0);
        check("rst_addr", imem_addr_o, RST_PC);
        check("rst_busy", {31'b0, fetch_busy_o}, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        model_reset();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBAD1_BAD1);
        check("post_rst_valid", {31'b0, valid_D_o}, 32'd0);
        check("post_rst_addr", imem_addr_o, RST_PC);
    endtask

    initial begin
        logic src, sf, sd, fl, g, rv;
        logic [31:0] tgt, rd;
        model_reset();
        @(negedge clk_i);
        do_reset();

        // Free run: grant every request, respond the cycle after
        for (int i = 0; i < 6; i++)
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, m_inflight, mem_word(m_addr));
        check("run_pc_D", pc_D_o, 32'h8000_0008);
        check("run_pc4_D", pc_plus4_D_o, 32'h8000_000C);
        check("run_instr", instr_D_o, mem_word(32'h8000_0008));

        // Flush together with stall while IF/ID is valid
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("flush_valid", {31'b0, valid_D_o}, 32'd0);
        check("flush_instr", instr_D_o, NOP);

        // Redirect one cycle before rvalid
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
        check("redir_wait_valid", {31'b0, valid_D_o}, 32'd0);
        check("redir_wait_addr", imem_addr_o, 32'h8000_0100);

        // Redirect coincident with rvalid
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 32'h8000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_2222);
        check("redir_rv_valid", {31'b0, valid_D_o}, 32'd0);
        check("redir_rv_addr", imem_addr_o, 32'h8000_0200);

        // Response under stall_D parks in HOLD, released when stall drops
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("hold_busy", {31'b0, fetch_busy_o}, 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("hold_instr", instr_D_o, 32'hDEAD_BEEF);
        check("hold_pc_D", pc_D_o, 32'h8000_0200);

        // PC wrap; target low bits are dropped
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("wrap_target", imem_addr_o, 32'hFFFF_FFFC);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("wrap_addr", imem_addr_o, 32'h0000_0000);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mem_word(32'hFFFF_FFFC));
        check("wrap_pc4_D", pc_plus4_D_o, 32'h0000_0000);

        // Reset in the middle of a transaction
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        do_reset();

        // Randomized traffic with occasional mid-run resets
        for (int n = 0; n < 4000; n++) begin
            if (n % 700 == 699) do_reset();
            src = ($urandom_range(7) == 0);
            tgt = ($urandom_range(15) == 0) ? 32'hFFFF_FFFD : $urandom;
            sf  = ($urandom_range(4) == 0);
            sd  = ($urandom_range(3) == 0);
            fl  = ($urandom_range(15) == 0);
            g   = $urandom_range(1) == 1;
            if (m_inflight) begin
                rv = ($urandom_range(2) == 0);
                rd = mem_word(m_addr);
            end else begin
                rv = ($urandom_range(7) == 0);
                rd = $urandom;
            end
            cycle(src, tgt, sf, sd, fl, g, rv, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage feeding the decode stage of the pipelined RISC-V core.
- Holds the fetch PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Delivers instruction, PC and PC+4 into the IF/ID register.
- Takes branch/jump redirects (pc_src_i, pc_target_i) from execute, and stall/flush from the hazard unit.
- Owns the PC register, so it replaces the PC-next selection with its own registered update.

Parameters:
RESET_PC, 32'h80000000, fetch address after reset
NOP_INSTR, 32'h00000013, instruction word driven on instr_D_o when no valid instruction is present (addi x0,x0,0)

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  asynchronous, active-high reset
stall_F_i  input  1  hazard unit: do not issue a new fetch request
stall_D_i  input  1  hazard unit: IF/ID register must hold its contents
flush_D_i  input  1  hazard unit: IF/ID register becomes a bubble
pc_src_i  input  1  redirect request from execute
pc_target_i  input  32  redirect target address
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch address, word aligned
imem_gnt_i  input  1  memory accepted the request this cycle
imem_rvalid_i  input  1  read data valid for the oldest accepted request
imem_rdata_i  input  32  read data
instr_D_o  output  32  IF/ID instruction
pc_D_o  output  32  IF/ID PC
pc_plus4_D_o  output  32  IF/ID PC+4
valid_D_o  output  1  IF/ID holds a real instruction
fetch_busy_o  output  1  high when the state is not REQ

Behaviour:
Reset values (reset_i high, asynchronous):
- state=REQ; pc_F=RESET_PC; pc_req=RESET_PC; kill=0; buffer empty.
- instr_D_o=NOP_INSTR; pc_D_o=0; pc_plus4_D_o=0; valid_D_o=0.

Handshake rules:
- imem_req_o = (state==REQ) & !stall_F_i.
- imem_addr_o = pc_F.
- Address may change while req is high and gnt is low (no stability requirement before grant).
- At most one request outstanding. imem_rvalid_i outside WAIT is ignored.

State REQ:
- req & gnt: pc_req<=pc_F; pc_F<=pc_F+4 (mod 2^32, wraps at 0xFFFFFFFC->0); go WAIT.
- pc_src_i in the same cycle: pc_F<=pc_target_i and kill<=1 instead.
- pc_src_i without gnt: pc_F<=pc_target_i; stay REQ.

State WAIT:
- req=0.
- pc_src_i (any cycle, including the rvalid cycle): pc_F<=pc_target_i; kill<=1.
- rvalid & (kill | pc_src_i): discard data; kill<=0; go REQ.
- rvalid & !kill & !pc_src_i & !stall_D_i: load IF/ID with rdata, pc_req, pc_req+4, valid=1; go REQ.
- rvalid & !kill & !pc_src_i & stall_D_i: capture into buffer; go HOLD.

State HOLD:
- req=0.
- pc_src_i: drop buffer; pc_F<=pc_target_i; go REQ.
- else if !stall_D_i: move buffer into IF/ID (valid=1); go REQ.

IF/ID register update priority, per cycle:
1. flush_D_i: valid<=0, instr<=NOP_INSTR, pc fields <=0. Overrides stall_D_i and any load. A response arriving in the same cycle is still subject to the kill/redirect rules; otherwise it is discarded.
2. stall_D_i: hold.
3. New instruction available (WAIT rvalid or HOLD release): load.
4. Otherwise: bubble (valid<=0, instr<=NOP_INSTR), pc fields hold.

Timing and sequencing:
- Latency is one cycle from a rvalid cycle to IF/ID visibility.
- Minimum of 2 cycles per instruction: REQ with gnt, then WAIT with rvalid.
- stall_F_i in WAIT or HOLD has no effect. It only gates new requests.
- After a redirect, the first instruction in IF/ID is always the one at pc_target_i.
- Reset mid-transaction: state returns to REQ and the later stale rvalid is ignored. The memory side must also be reset by the same reset_i.
- Width rules: all PC arithmetic is 32-bit unsigned and discards carry. pc_target_i bits [1:0] are forced to 0 on load.

Test Plan:
- Reset then free-run: gnt=1, rvalid one cycle after gnt -> addresses 0x80000000, 0x80000004, 0x80000008. IF/ID shows matching pc_D_o/pc_plus4_D_o (0x80000000/0x80000004, ...) with valid_D_o=1 every second cycle.
- Redirect while WAIT: pc_src_i=1, target 0x80000100, one cycle before rvalid -> returned word dropped, valid_D_o stays 0, next imem_addr_o=0x80000100.
- Redirect coincident with rvalid (kill=0) -> data dropped, next req at target, valid_D_o=0 that cycle.
- stall_D_i held 3 cycles when rvalid arrives with 0xDEADBEEF -> state HOLD, IF/ID unchanged. 0xDEADBEEF appears the cycle after stall drops, and no new req is issued during HOLD.
- flush_D_i together with stall_D_i while valid_D_o=1 -> next cycle valid_D_o=0, instr_D_o=0x00000013.
- Async reset asserted in WAIT and rvalid pulsed during/after reset -> outputs at reset values, no IF/ID load, first request at 0x80000000. Separately, PC wrap: redirect to 0xFFFFFFFC -> next sequential address 0x00000000.
